target_locator: RTL and testbench
=================================

// Module: target_locator
// PURPOSE
//  Downstream of the YCbCr colour binarization stage. Consumes the 1-bit
//  colour-mask pixel stream and, per frame, measures the detected object:
//  bounding box, pixel count and (optional) centroid. Reports once per frame
//  to the arm-control logic, which uses the result to pick the grab target.
// PARAMETERS
//  IMG_W    640  active pixels per line; pixels with x >= IMG_W are ignored
//  IMG_H    480  active lines per frame; lines with y >= IMG_H are ignored
//  XW       10   width of x/y coordinates and box outputs
//  CW       19   width of the pixel counter (saturates at 2^CW-1)
//  MIN_PIX  64   minimum mask-pixel count for target_found
// PORTS
//  clk               in   1   pixel clock
//  rst_n             in   1   asynchronous reset, active low
//  per_frame_vsync   in   1   frame sync, active high; rising edge = frame boundary
//  per_frame_href    in   1   line valid
//  per_frame_clken   in   1   pixel valid (qualified by href)
//  per_img_Bit       in   1   mask pixel, 1 = object colour
//  box_xmin/box_xmax out  XW  bounding-box columns of last complete frame
//  box_ymin/box_ymax out  XW  bounding-box rows of last complete frame
//  pix_cnt           out  CW  mask-pixel count of last complete frame
//  cen_x/cen_y       out  XW  centroid (0 when CENTROID_EN is not defined)
//  target_found      out  1   pix_cnt >= MIN_PIX for last complete frame
//  result_valid      out  1   one-clk pulse: all result outputs just updated
// BEHAVIOUR
//  - Reset: every output 0; x, y, accumulators cleared; FSM to IDLE.
//  - vsync is registered once; vs_rise = vsync & ~vsync_d.
//  - x counts pixels with href & clken and is cleared while href = 0. y
//    increments on each href falling edge and is cleared on vs_rise.
//  - A pixel is accumulated only if href & clken & Bit & x<IMG_W & y<IMG_H:
//    xmin/xmax/ymin/ymax update by compare; cnt increments and saturates.
//    Working min regs start at all-ones and max regs at 0 on every vs_rise.
//  - FSM: IDLE -(vs_rise)-> ACCUM. ACCUM -(vs_rise)-> LATCH; working regs are
//    snapshotted and cleared in the same cycle, so accumulation of the next
//    frame starts without a gap. LATCH -> DONE (or -> DIV with CENTROID_EN).
//    DONE -> ACCUM. The first vs_rise after reset produces no result.
//  - LATCH/DONE: outputs load from the snapshot. If cnt < MIN_PIX then
//    target_found = 0 and box and cen outputs are forced to 0.
//  - result_valid is high for exactly one clk. It rises 2 clks after the
//    clk at which vs_rise is detected. With CENTROID_EN, the delay is 2+XW.
//    Outputs hold between pulses.
//  - vs_rise while in DIV: the divide restarts on the new snapshot and the
//    older result is dropped. There is no result_valid for the older frame.
//  - Reset asserted mid-frame: partial data is discarded, FSM returns to IDLE.
// CONFIGURATION
//  CENTROID_EN defined: accumulate sum_x, sum_y (width XW+XW+CW,
//   no overflow at full frame). Two parallel restoring dividers compute
//   sum/cnt in the DIV state over XW clks, one quotient bit per clk. The
//   quotient is truncated and drives cen_x/cen_y. cnt = 0 skips the divide
//   and gives cen = 0.
//  CENTROID_EN undefined: no sums and no divider. cen_x/cen_y are tied to 0
//   and LATCH goes directly to DONE.
// TESTING
//  1 Reset mid-stream, then 2 blank frames -> first vs_rise gives no pulse;
//    second gives result_valid once, target_found=0, all results 0.
//  2 Block x=100..149, y=200..239 (2000 px) -> box 100/149/200/239,
//    pix_cnt=2000, found=1; with CENTROID_EN cen=(124,219).
//  3 Single pixel x=0,y=0 with MIN_PIX=1 -> box all 0, pix_cnt=1, found=1.
//    Pixel x=639,y=479 -> box 639/639/479/479.
//  4 63 mask pixels (MIN_PIX=64) -> found=0, box and cen 0, pix_cnt=63.
//    Mask pixels at x>=IMG_W or y>=IMG_H -> not counted.
//  5 Back-to-back frames A, B with different blocks -> two pulses; outputs
//    match A, then B. Latency is exactly 2 clks (2+XW with CENTROID_EN).
//  6 CENTROID_EN, second vs_rise injected during DIV -> only the later
//    frame's result_valid appears, with correct values.

Source files
------------

// File: rtl/target_locator.sv
// target_locator: per-frame bounding box, pixel count and optional centroid of a 1-bit mask stream.
// Define CENTROID_EN to add the coordinate sums and the sequential centroid dividers.
module target_locator #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int XW      = 10,
  parameter int CW      = 19,
  parameter int MIN_PIX = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_frame_vsync,
  input  logic          per_frame_href,
  input  logic          per_frame_clken,
  input  logic          per_img_Bit,
  output logic [XW-1:0] box_xmin,
  output logic [XW-1:0] box_xmax,
  output logic [XW-1:0] box_ymin,
  output logic [XW-1:0] box_ymax,
  output logic [CW-1:0] pix_cnt,
  output logic [XW-1:0] cen_x,
  output logic [XW-1:0] cen_y,
  output logic          target_found,
  output logic          result_valid
);
  localparam logic [XW-1:0] W_LIM   = XW'(IMG_W);
  localparam logic [XW-1:0] H_LIM   = XW'(IMG_H);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIX);

  typedef enum logic [2:0] {IDLE, ACCUM, LATCH, DIV, DONE} state_t;

  state_t        state_q;
  logic          vsync_q, href_q, vs_rise, pix_ok, found;
  logic [XW-1:0] x_q, y_q, xmin_q, xmax_q, ymin_q, ymax_q;
  logic [XW-1:0] s_xmin_q, s_xmax_q, s_ymin_q, s_ymax_q;
  logic [CW-1:0] cnt_q, s_cnt_q;

  assign vs_rise = per_frame_vsync & ~vsync_q;
  assign pix_ok  = per_frame_href & per_frame_clken & per_img_Bit & (x_q < W_LIM) & (y_q < H_LIM);
  assign found   = s_cnt_q >= MIN_CNT;

`ifdef CENTROID_EN
  localparam int SW = 2*XW + CW;
  localparam int KW = $clog2(XW);
  logic [SW-1:0] sx_q, sy_q, rx_q, ry_q, den_q;
  logic [XW-1:0] qx_q, qy_q;
  logic [KW-1:0] k_q;
  logic          gex, gey;
  assign gex = rx_q >= den_q;
  assign gey = ry_q >= den_q;
`else
  assign cen_x = '0;
  assign cen_y = '0;
`endif

  // Working accumulators re-initialise on every frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      xmin_q  <= '1;
      xmax_q  <= '0;
      ymin_q  <= '1;
      ymax_q  <= '0;
      cnt_q   <= '0;
`ifdef CENTROID_EN
      sx_q    <= '0;
      sy_q    <= '0;
`endif
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      x_q     <= !per_frame_href ? '0 : (per_frame_clken && x_q != '1) ? x_q + 1'b1 : x_q;
      y_q     <= vs_rise ? '0 : (href_q && !per_frame_href && y_q != '1) ? y_q + 1'b1 : y_q;
      if (vs_rise) begin
        xmin_q <= '1;
        xmax_q <= '0;
        ymin_q <= '1;
        ymax_q <= '0;
        cnt_q  <= '0;
`ifdef CENTROID_EN
        sx_q   <= '0;
        sy_q   <= '0;
`endif
      end else if (pix_ok) begin
        xmin_q <= x_q < xmin_q ? x_q : xmin_q;
        xmax_q <= x_q > xmax_q ? x_q : xmax_q;
        ymin_q <= y_q < ymin_q ? y_q : ymin_q;
        ymax_q <= y_q > ymax_q ? y_q : ymax_q;
        cnt_q  <= cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
`ifdef CENTROID_EN
        sx_q   <= sx_q + SW'(x_q);
        sy_q   <= sy_q + SW'(y_q);
`endif
      end
    end
  end

  // Any frame boundary outside IDLE snapshots the frame, restarting a divide in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_xmin_q     <= '0;
      s_xmax_q     <= '0;
      s_ymin_q     <= '0;
      s_ymax_q     <= '0;
      s_cnt_q      <= '0;
      box_xmin     <= '0;
      box_xmax     <= '0;
      box_ymin     <= '0;
      box_ymax     <= '0;
      pix_cnt      <= '0;
      target_found <= 1'b0;
      result_valid <= 1'b0;
`ifdef CENTROID_EN
      rx_q         <= '0;
      ry_q         <= '0;
      den_q        <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      k_q          <= '0;
      cen_x        <= '0;
      cen_y        <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      if (state_q == DONE) begin
        result_valid <= 1'b1;
        target_found <= found;
        pix_cnt      <= s_cnt_q;
        box_xmin     <= found ? s_xmin_q : '0;
        box_xmax     <= found ? s_xmax_q : '0;
        box_ymin     <= found ? s_ymin_q : '0;
        box_ymax     <= found ? s_ymax_q : '0;
`ifdef CENTROID_EN
        cen_x        <= (found && s_cnt_q != '0) ? qx_q : '0;
        cen_y        <= (found && s_cnt_q != '0) ? qy_q : '0;
`endif
      end
      if (vs_rise && state_q != IDLE) begin
        state_q  <= LATCH;
        s_xmin_q <= xmin_q;
        s_xmax_q <= xmax_q;
        s_ymin_q <= ymin_q;
        s_ymax_q <= ymax_q;
        s_cnt_q  <= cnt_q;
`ifdef CENTROID_EN
        rx_q     <= sx_q;
        ry_q     <= sy_q;
`endif
      end else begin
        case (state_q)
          IDLE:  state_q <= vs_rise ? ACCUM : IDLE;
          ACCUM: state_q <= ACCUM;
          LATCH: begin
`ifdef CENTROID_EN
            den_q   <= SW'(s_cnt_q) << (XW-1);
            k_q     <= '0;
            state_q <= DIV;
`else
            state_q <= DONE;
`endif
          end
`ifdef CENTROID_EN
          DIV: begin
            rx_q    <= gex ? rx_q - den_q : rx_q;
            ry_q    <= gey ? ry_q - den_q : ry_q;
            qx_q    <= {qx_q[XW-2:0], gex};
            qy_q    <= {qy_q[XW-2:0], gey};
            den_q   <= den_q >> 1;
            k_q     <= k_q + 1'b1;
            state_q <= k_q == KW'(XW-1) ? DONE : DIV;
          end
`endif
          DONE:    state_q <= ACCUM;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_target_locator.sv
// tb_target_locator: frame-level vectors with a result scoreboard on two instances (MIN_PIX 64 and 1).
module tb_target_locator;
  localparam int XW = 10;
  localparam int CW = 19;
`ifdef CENTROID_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  localparam int LAT = CEN ? 3 + XW : 3;

  typedef struct {int xmin, xmax, ymin, ymax, cnt, cx, cy;} res_t;
  typedef struct {int x0, x1, y0, y1; res_t e;} vec_t;
  typedef struct {res_t e; int due;} exp_t;

  logic clk = 1'b0, rst_n = 1'b0, vs = 1'b0, href = 1'b0, clken = 1'b0, bitv = 1'b0;
  logic [XW-1:0] a_xmin, a_xmax, a_ymin, a_ymax, a_cx, a_cy;
  logic [XW-1:0] b_xmin, b_xmax, b_ymin, b_ymax, b_cx, b_cy;
  logic [CW-1:0] a_cnt, b_cnt;
  logic a_f, a_rv, b_f, b_rv;
  int cyc = 0, checks = 0, failures = 0;
  exp_t q[$];
  vec_t tbl[7];
  res_t zero_r, frc, frd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  target_locator #(.MIN_PIX(64)) u_a (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bitv),
    .box_xmin(a_xmin), .box_xmax(a_xmax), .box_ymin(a_ymin), .box_ymax(a_ymax),
    .pix_cnt(a_cnt), .cen_x(a_cx), .cen_y(a_cy), .target_found(a_f), .result_valid(a_rv));

  target_locator #(.MIN_PIX(1)) u_b (
    .clk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(href),
    .per_frame_clken(clken), .per_img_Bit(bitv),
    .box_xmin(b_xmin), .box_xmax(b_xmax), .box_ymin(b_ymin), .box_ymax(b_ymax),
    .pix_cnt(b_cnt), .cen_x(b_cx), .cen_y(b_cy), .target_found(b_f), .result_valid(b_rv));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_dut(string t, int mp, res_t e, int f, int cnt, int x0, int x1,
                         int y0, int y1, int cx, int cy);
    bit g = e.cnt >= mp;
    chk({t, ".found"}, f, int'(g));
    chk({t, ".pix_cnt"}, cnt, e.cnt);
    chk({t, ".box_xmin"}, x0, g ? e.xmin : 0);
    chk({t, ".box_xmax"}, x1, g ? e.xmax : 0);
    chk({t, ".box_ymin"}, y0, g ? e.ymin : 0);
    chk({t, ".box_ymax"}, y1, g ? e.ymax : 0);
    chk({t, ".cen_x"}, cx, (g && CEN) ? e.cx : 0);
    chk({t, ".cen_y"}, cy, (g && CEN) ? e.cy : 0);
  endtask

  task automatic chk_rst(string ph);
    chk({ph, ".A_any_output"}, int'(|{a_xmin, a_xmax, a_ymin, a_ymax, a_cx, a_cy, a_cnt, a_f, a_rv}), 0);
    chk({ph, ".B_any_output"}, int'(|{b_xmin, b_xmax, b_ymin, b_ymax, b_cx, b_cy, b_cnt, b_f, b_rv}), 0);
  endtask

  always @(negedge clk) begin : mon
    exp_t x;
    if (rst_n && (a_rv || b_rv)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: result_valid A=%0b B=%0b with no pending frame (cycle %0d)", a_rv, b_rv, cyc);
      end else begin
        x = q.pop_front();
        chk("latency_cycle", cyc, x.due);
        chk("A.result_valid", int'(a_rv), 1);
        chk("B.result_valid", int'(b_rv), 1);
        chk_dut("A", 64, x.e, int'(a_f), int'(a_cnt), int'(a_xmin), int'(a_xmax),
                int'(a_ymin), int'(a_ymax), int'(a_cx), int'(a_cy));
        chk_dut("B", 1, x.e, int'(b_f), int'(b_cnt), int'(b_xmin), int'(b_xmax),
                int'(b_ymin), int'(b_ymax), int'(b_cx), int'(b_cy));
      end
    end
  end

  // A clken-low cycle with the mask bit high is slipped into every pixel line.
  task automatic line(int n, int x0, int x1);
    if (n == 0) begin
      @(negedge clk); href = 1'b1; clken = 1'b0; bitv = 1'b0;
    end else begin
      for (int x = 0; x < n; x++) begin
        if (x == n / 2) begin
          @(negedge clk); href = 1'b1; clken = 1'b0; bitv = 1'b1;
        end
        @(negedge clk); href = 1'b1; clken = 1'b1; bitv = (x >= x0 && x <= x1);
      end
    end
    @(negedge clk); href = 1'b0; clken = 1'b0; bitv = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame(int x0, int x1, int y0, int y1);
    for (int y = 0; y <= y1; y++) line(y < y0 ? 0 : x1 + 1, x0, x1);
    repeat (16) @(negedge clk);
  endtask

  task automatic vs_pulse(bit push, res_t e);
    @(negedge clk); vs = 1'b1;
    if (push) q.push_back('{e, cyc + LAT});
    @(negedge clk); vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{100, 149, 200, 239, '{100, 149, 200, 239, 2000, 124, 219}};
    tbl[1] = '{0, 0, 0, 0, '{0, 0, 0, 0, 1, 0, 0}};
    tbl[2] = '{639, 639, 479, 479, '{639, 639, 479, 479, 1, 639, 479}};
    tbl[3] = '{10, 72, 5, 5, '{10, 72, 5, 5, 63, 41, 5}};
    tbl[4] = '{630, 649, 2, 2, '{630, 639, 2, 2, 10, 634, 2}};
    tbl[5] = '{5, 6, 478, 481, '{5, 6, 478, 479, 4, 5, 478}};
    tbl[6] = '{300, 363, 10, 11, '{300, 363, 10, 11, 128, 331, 10}};
    zero_r = '{0, 0, 0, 0, 0, 0, 0};
    frc    = '{20, 29, 3, 4, 20, 24, 3};
    frd    = '{1, 1, 0, 0, 1, 1, 0};

    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vs_pulse(1'b0, zero_r);

    for (int i = 0; i < 7; i++) begin
      frame(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1);
      vs_pulse(1'b1, tbl[i].e);
    end
    drain();

    // Frame C ends, then a tiny frame D ends while C's divide is still running.
    frame(20, 29, 3, 4);
    vs_pulse(!CEN, frc);
    line(3, 1, 1);
    vs_pulse(1'b1, frd);
    drain();

    frame(0, 49, 0, 2);
    @(negedge clk); href = 1'b1; clken = 1'b1; bitv = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_rst("midframe_reset");
    @(negedge clk); href = 1'b0; clken = 1'b0; bitv = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vs_pulse(1'b0, zero_r);
    repeat (20) @(negedge clk);
    vs_pulse(1'b1, zero_r);
    drain();
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
